// File: rtl/mem_pkg.sv
// Shared encodings and pipeline record types for the memory-access stage.
// Pure declarations: no latency or backpressure of its own.
package mem_pkg;

  localparam logic [1:0] MSZ_WORD = 2'b00;
  localparam logic [1:0] MSZ_HALF = 2'b01;
  localparam logic [1:0] MSZ_BYTE = 2'b10;

  localparam logic [3:0] INS_TYPE_BUBBLE = 4'd0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  // Fields parked while a data-memory access is outstanding.
  typedef struct packed {
    logic [4:0]  dest_r;
    logic [31:0] alu_r;
    logic        wreg;
    logic        m2reg;
    logic [1:0]  msize;
    logic        msigned;
    logic [3:0]  ins_type;
    logic [3:0]  ins_number;
  } pend_t;

  // MEM/WB operand set handed to the writeback stage.
  typedef struct packed {
    logic [4:0]  dest_r;
    logic [31:0] alu_r;
    logic [31:0] mdata;
    logic        wreg;
    logic        m2reg;
    logic [3:0]  ins_type;
    logic [3:0]  ins_number;
  } wb_t;

  function automatic logic is_memop(input logic m2reg, input logic wmem);
    return m2reg | wmem;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge port; master issues the request, slave acks.
// Latency: variable wait states; request is held stable by the master until ack.
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (
    output req, we, addr, be, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/mem_align.sv
// Byte-lane alignment for stores, extraction/extension for loads, misalign detect.
// Latency: combinational; backpressure: none.
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        msigned,
  input  logic [1:0]  addr,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        misalign
);

  logic [15:0] lhalf;
  logic [7:0]  lbyte;

  always_comb begin
    lhalf = addr[1] ? rdata[31:16] : rdata[15:0];
    case (addr)
      2'd0:    lbyte = rdata[7:0];
      2'd1:    lbyte = rdata[15:8];
      2'd2:    lbyte = rdata[23:16];
      default: lbyte = rdata[31:24];
    endcase
  end

  // Size 11 falls through to the word behaviour.
  always_comb begin
    be       = 4'b1111;
    wdata    = sdata;
    ldata    = rdata;
    misalign = |addr;
    case (size)
      MSZ_HALF: begin
        be       = addr[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{sdata[15:0]}};
        ldata    = {{16{msigned & lhalf[15]}}, lhalf};
        misalign = addr[0];
      end
      MSZ_BYTE: begin
        be       = 4'b0001 << addr;
        wdata    = {4{sdata[7:0]}};
        ldata    = {{24{msigned & lbyte[7]}}, lbyte};
        misalign = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: registers EX/MEM, runs loads/stores over dmem; 1 cycle (ALU) or 1+N (memop).
// Backpressure: mem_stall holds upstream from capture until the ack cycle; outputs carry bubbles meanwhile.
module mem_stage
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ex_destR,
  input  logic [31:0] ex_aluR,
  input  logic [31:0] ex_sdata,
  input  logic        ex_wreg,
  input  logic        ex_m2reg,
  input  logic        ex_wmem,
  input  logic [1:0]  ex_msize,
  input  logic        ex_msigned,
  input  logic [3:0]  EX_ins_type,
  input  logic [3:0]  EX_ins_number,
  output logic [4:0]  mem_destR,
  output logic [31:0] mem_aluR,
  output logic [31:0] mem_mdata,
  output logic        mem_wreg,
  output logic        mem_m2reg,
  output logic [3:0]  MEM_ins_type,
  output logic [3:0]  MEM_ins_number,
  output logic        mem_stall,
  output logic        mem_misalign,
  mem_stage_if.master dmem
);

  state_t      state_q, state_d;
  pend_t       pend_q;
  wb_t         wb_q, wb_d;
  logic        misalign_q, misalign_d;
  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;

  logic        memop, in_req, capture, done;
  logic [1:0]  al_size, al_addr;
  logic        al_signed;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_ldata;
  logic        al_misalign;

  assign memop  = is_memop(ex_m2reg, ex_wmem);
  assign in_req = (state_q == S_REQ);

  // One aligner serves both directions: EX fields when idle, parked fields while waiting.
  assign al_size   = in_req ? pend_q.msize      : ex_msize;
  assign al_signed = in_req ? pend_q.msigned    : ex_msigned;
  assign al_addr   = in_req ? pend_q.alu_r[1:0] : ex_aluR[1:0];

  mem_align u_align (
    .size     (al_size),
    .msigned  (al_signed),
    .addr     (al_addr),
    .sdata    (ex_sdata),
    .rdata    (dmem.rdata),
    .be       (al_be),
    .wdata    (al_wdata),
    .ldata    (al_ldata),
    .misalign (al_misalign)
  );

  assign capture = !in_req && memop && !al_misalign;
  assign done    = in_req && dmem.ack;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (capture)  state_d = S_REQ;
      S_REQ:   if (dmem.ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wb_d          = '0;
    wb_d.ins_type = INS_TYPE_BUBBLE;
    misalign_d    = 1'b0;
    mem_stall     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!memop) begin
          wb_d.dest_r     = ex_destR;
          wb_d.alu_r      = ex_aluR;
          wb_d.wreg       = ex_wreg;
          wb_d.m2reg      = ex_m2reg;
          wb_d.ins_type   = EX_ins_type;
          wb_d.ins_number = EX_ins_number;
        end else if (al_misalign) begin
          misalign_d = 1'b1;
        end else begin
          mem_stall = 1'b1;
        end
      end
      S_REQ: begin
        if (dmem.ack) begin
          wb_d.dest_r     = pend_q.dest_r;
          wb_d.alu_r      = pend_q.alu_r;
          wb_d.mdata      = we_q ? 32'd0 : al_ldata;
          wb_d.wreg       = pend_q.wreg;
          wb_d.m2reg      = pend_q.m2reg;
          wb_d.ins_type   = pend_q.ins_type;
          wb_d.ins_number = pend_q.ins_number;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_q       <= '0;
      misalign_q <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      pend_q     <= '0;
    end else begin
      wb_q       <= wb_d;
      misalign_q <= misalign_d;
      if (capture) begin
        req_q             <= 1'b1;
        we_q              <= ex_wmem;
        addr_q            <= {ex_aluR[31:2], 2'b00};
        be_q              <= al_be;
        wdata_q           <= al_wdata;
        pend_q.dest_r     <= ex_destR;
        pend_q.alu_r      <= ex_aluR;
        pend_q.wreg       <= ex_wreg;
        pend_q.m2reg      <= ex_m2reg;
        pend_q.msize      <= ex_msize;
        pend_q.msigned    <= ex_msigned;
        pend_q.ins_type   <= EX_ins_type;
        pend_q.ins_number <= EX_ins_number;
      end else if (done) begin
        req_q <= 1'b0;
      end
    end
  end

  assign mem_destR      = wb_q.dest_r;
  assign mem_aluR       = wb_q.alu_r;
  assign mem_mdata      = wb_q.mdata;
  assign mem_wreg       = wb_q.wreg;
  assign mem_m2reg      = wb_q.m2reg;
  assign MEM_ins_type   = wb_q.ins_type;
  assign MEM_ins_number = wb_q.ins_number;
  assign mem_misalign   = misalign_q;

  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.be    = be_q;
  assign dmem.wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized checks of mem_stage against an arithmetic reference model.
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ex_destR;
  logic [31:0] ex_aluR, ex_sdata;
  logic        ex_wreg, ex_m2reg, ex_wmem;
  logic [1:0]  ex_msize;
  logic        ex_msigned;
  logic [3:0]  EX_ins_type, EX_ins_number;
  logic [4:0]  mem_destR;
  logic [31:0] mem_aluR, mem_mdata;
  logic        mem_wreg, mem_m2reg;
  logic [3:0]  MEM_ins_type, MEM_ins_number;
  logic        mem_stall, mem_misalign;

  int checks = 0;
  int errors = 0;
  int ins_num = 0;

  always #5 clk = ~clk;

  mem_stage_if dmem_bus ();

  mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .ex_destR       (ex_destR),
    .ex_aluR        (ex_aluR),
    .ex_sdata       (ex_sdata),
    .ex_wreg        (ex_wreg),
    .ex_m2reg       (ex_m2reg),
    .ex_wmem        (ex_wmem),
    .ex_msize       (ex_msize),
    .ex_msigned     (ex_msigned),
    .EX_ins_type    (EX_ins_type),
    .EX_ins_number  (EX_ins_number),
    .mem_destR      (mem_destR),
    .mem_aluR       (mem_aluR),
    .mem_mdata      (mem_mdata),
    .mem_wreg       (mem_wreg),
    .mem_m2reg      (mem_m2reg),
    .MEM_ins_type   (MEM_ins_type),
    .MEM_ins_number (MEM_ins_number),
    .mem_stall      (mem_stall),
    .mem_misalign   (mem_misalign),
    .dmem           (dmem_bus)
  );

  // Reference model: spec rules as plain arithmetic.
  function automatic bit m_misalign(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b01) return (a % 2) != 0;
    if (sz == 2'b10) return 1'b0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b01) return ((a % 4) >= 2) ? 4'd12 : 4'd3;
    if (sz == 2'b10) return 4'(1 << (a % 4));
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] s);
    if (sz == 2'b01) return (s & 32'hFFFF) * 32'h0001_0001;
    if (sz == 2'b10) return (s & 32'hFF) * 32'h0101_0101;
    return s;
  endfunction

  function automatic logic [31:0] m_ldata(input logic [1:0] sz, input bit sgn,
                                          input logic [31:0] a, input logic [31:0] r);
    logic [31:0] v;
    v = r >> (8 * (a % 4));
    if (sz == 2'b01) begin
      v = v & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v - 32'h1_0000;
      return v;
    end
    if (sz == 2'b10) begin
      v = v & 32'hFF;
      if (sgn && v >= 32'h80) v = v - 32'h100;
      return v;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic next_num(output logic [3:0] n);
    ins_num = ins_num + 1;
    n = 4'(ins_num);
  endtask

  // Non-memory instruction: one cycle straight through.
  task automatic nop_step(input logic [4:0] d, input logic [31:0] alu);
    logic [3:0] n;
    next_num(n);
    ex_destR = d; ex_aluR = alu; ex_sdata = $urandom;
    ex_wreg = 1'b1; ex_m2reg = 1'b0; ex_wmem = 1'b0;
    ex_msize = 2'($urandom_range(0, 3)); ex_msigned = 1'($urandom_range(0, 1));
    EX_ins_type = 4'd1; EX_ins_number = n;
    #1;
    chk("nop_stall", mem_stall, 0);
    tick();
    chk("nop_destR", mem_destR, d);
    chk("nop_aluR", mem_aluR, alu);
    chk("nop_mdata", mem_mdata, 0);
    chk("nop_wreg", mem_wreg, 1);
    chk("nop_m2reg", mem_m2reg, 0);
    chk("nop_type", MEM_ins_type, 1);
    chk("nop_num", MEM_ins_number, n);
    chk("nop_misalign", mem_misalign, 0);
    chk("nop_req", dmem_bus.req, 0);
  endtask

  task automatic memop(input bit is_load, input logic [1:0] sz, input bit sgn,
                       input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [31:0] rdata, input int waits, input logic [4:0] d);
    logic [3:0] n;
    int stalls;
    next_num(n);
    stalls = 0;
    ex_destR = d; ex_aluR = addr; ex_sdata = sdata;
    ex_wreg = is_load; ex_m2reg = is_load; ex_wmem = !is_load;
    ex_msize = sz; ex_msigned = sgn;
    EX_ins_type = is_load ? 4'd2 : 4'd3; EX_ins_number = n;
    dmem_bus.ack = 1'b0;
    #1;
    if (m_misalign(sz, addr)) begin
      chk("misal_stall", mem_stall, 0);
      tick();
      chk("misal_pulse", mem_misalign, 1);
      chk("misal_noreq", dmem_bus.req, 0);
      chk("misal_wreg", mem_wreg, 0);
      chk("misal_num", MEM_ins_number, 0);
      nop_step(5'($urandom), $urandom);
      return;
    end
    chk("cap_stall", mem_stall, 1);
    if (mem_stall) stalls++;
    tick();
    chk("req_up", dmem_bus.req, 1);
    chk("req_we", dmem_bus.we, !is_load);
    chk("req_addr", dmem_bus.addr, addr & 32'hFFFF_FFFC);
    chk("req_be", dmem_bus.be, m_be(sz, addr));
    if (!is_load) chk("req_wdata", dmem_bus.wdata, m_wdata(sz, sdata));
    chk("bub_wreg", mem_wreg, 0);
    chk("bub_m2reg", mem_m2reg, 0);
    chk("bub_destR", mem_destR, 0);
    chk("bub_num", MEM_ins_number, 0);
    // Upstream contents while waiting must not matter.
    ex_destR = 5'($urandom); ex_aluR = $urandom; ex_sdata = $urandom;
    ex_wreg = 1'($urandom_range(0, 1)); ex_m2reg = 1'($urandom_range(0, 1));
    ex_wmem = 1'($urandom_range(0, 1)); ex_msize = 2'($urandom_range(0, 3));
    EX_ins_type = 4'($urandom); EX_ins_number = 4'($urandom);
    for (int w = 0; w < waits; w++) begin
      dmem_bus.rdata = $urandom;
      #1;
      if (mem_stall) stalls++;
      tick();
      chk("wait_req", dmem_bus.req, 1);
      chk("wait_addr", dmem_bus.addr, addr & 32'hFFFF_FFFC);
      chk("wait_be", dmem_bus.be, m_be(sz, addr));
      chk("wait_wreg", mem_wreg, 0);
    end
    dmem_bus.rdata = rdata;
    dmem_bus.ack = 1'b1;
    #1;
    chk("ack_stall", mem_stall, 0);
    tick();
    dmem_bus.ack = 1'b0;
    chk("stall_cycles", stalls, waits + 1);
    chk("wb_mdata", mem_mdata, is_load ? m_ldata(sz, sgn, addr, rdata) : 32'd0);
    chk("wb_destR", mem_destR, d);
    chk("wb_aluR", mem_aluR, addr);
    chk("wb_wreg", mem_wreg, is_load);
    chk("wb_m2reg", mem_m2reg, is_load);
    chk("wb_type", MEM_ins_type, is_load ? 2 : 3);
    chk("wb_num", MEM_ins_number, n);
    chk("wb_req_down", dmem_bus.req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    rst = 1'b0;
    dmem_bus.ack = 1'b0;
    dmem_bus.rdata = 32'd0;
    ex_destR = 5'd3; ex_aluR = 32'h40; ex_sdata = 32'd0;
    ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_wmem = 1'b0;
    ex_msize = MSZ_WORD; ex_msigned = 1'b0;
    EX_ins_type = 4'd2; EX_ins_number = 4'd9;

    // Reset state
    tick();
    tick();
    chk("rst_destR", mem_destR, 0);
    chk("rst_aluR", mem_aluR, 0);
    chk("rst_mdata", mem_mdata, 0);
    chk("rst_wreg", mem_wreg, 0);
    chk("rst_m2reg", mem_m2reg, 0);
    chk("rst_type", MEM_ins_type, 0);
    chk("rst_num", MEM_ins_number, 0);
    chk("rst_misalign", mem_misalign, 0);
    chk("rst_req", dmem_bus.req, 0);
    chk("rst_addr", dmem_bus.addr, 0);
    chk("rst_be", dmem_bus.be, 0);
    rst = 1'b1;

    // ALU passthrough
    nop_step(5'd5, 32'h1234_5678);

    // Signed and unsigned byte loads, three wait states
    memop(1'b1, MSZ_BYTE, 1'b1, 32'h103, 32'd0, 32'h80FF_7F01, 3, 5'd7);
    chk("sbyte_mdata", mem_mdata, 32'hFFFF_FF80);
    chk("sbyte_addr", dmem_bus.addr, 32'h100);
    memop(1'b1, MSZ_BYTE, 1'b0, 32'h103, 32'd0, 32'h80FF_7F01, 3, 5'd7);
    chk("ubyte_mdata", mem_mdata, 32'h0000_0080);

    // Half store acked in the first wait cycle
    memop(1'b0, MSZ_HALF, 1'b0, 32'h2002, 32'hAAAA_BEEF, 32'd0, 0, 5'd0);

    // Misaligned word load
    memop(1'b1, MSZ_WORD, 1'b0, 32'h1001, 32'd0, 32'd0, 0, 5'd9);

    // Back-to-back loads, immediate ack
    memop(1'b1, MSZ_WORD, 1'b0, 32'h300, 32'd0, 32'hCAFE_F00D, 0, 5'd10);
    memop(1'b1, MSZ_HALF, 1'b1, 32'h306, 32'd0, 32'h9234_5678, 0, 5'd11);
    chk("b2b_half", mem_mdata, 32'hFFFF_9234);

    // Ack in IDLE is ignored
    dmem_bus.ack = 1'b1;
    dmem_bus.rdata = 32'hDEAD_BEEF;
    nop_step(5'd12, 32'h55);
    dmem_bus.ack = 1'b0;

    // Reset while a request is outstanding, ack on the reset edge
    ex_destR = 5'd13; ex_aluR = 32'h400; ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_wmem = 1'b0;
    ex_msize = MSZ_WORD; EX_ins_type = 4'd2; EX_ins_number = 4'd14;
    tick();
    chk("abort_req_up", dmem_bus.req, 1);
    rst = 1'b0;
    dmem_bus.ack = 1'b1;
    dmem_bus.rdata = 32'h1111_2222;
    tick();
    chk("abort_req", dmem_bus.req, 0);
    chk("abort_wreg", mem_wreg, 0);
    chk("abort_m2reg", mem_m2reg, 0);
    chk("abort_mdata", mem_mdata, 0);
    chk("abort_destR", mem_destR, 0);
    rst = 1'b1;
    dmem_bus.ack = 1'b0;
    nop_step(5'd15, 32'h77);

    // Randomized mix
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        nop_step(5'($urandom), $urandom);
      end else begin
        a = $urandom;
        if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
        memop(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              a, $urandom, $urandom, $urandom_range(0, 3), 5'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
